// File: rtl/elevator_controller.sv
// Three-floor elevator car controller: serves latched call lamps, travels one
// floor per TRAVEL_CYCLES, and holds the door for DOOR_CYCLES at each stop.
module elevator_controller #(
    parameter logic [1:0] labelF1       = 2'b00,
    parameter logic [1:0] labelF2       = 2'b01,
    parameter logic [1:0] labelF3       = 2'b10,
    parameter int         TRAVEL_CYCLES = 8,
    parameter int         DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       led1,
    input  logic       led2,
    input  logic       led3,
    output logic [1:0] floor,
    output logic       move_handler,
    output logic       dir_up,
    output logic       door_open,
    output logic       arrived
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [TW-1:0] TIMER_ZERO  = {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    // Internal floor index: 0 = lowest, 2 = highest.
    localparam logic [1:0] IDX_BOT = 2'd0;
    localparam logic [1:0] IDX_TOP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_MOVING = 2'b01,
        S_DOOR   = 2'b10
    } state_e;

    function automatic logic [1:0] floor_code(input logic [1:0] idx);
        case (idx)
            2'd0:    floor_code = labelF1;
            2'd1:    floor_code = labelF2;
            2'd2:    floor_code = labelF3;
            default: floor_code = labelF1;
        endcase
    endfunction

    function automatic logic lamp_at(input logic [1:0] idx, input logic [2:0] calls);
        case (idx)
            2'd0:    lamp_at = calls[0];
            2'd1:    lamp_at = calls[1];
            2'd2:    lamp_at = calls[2];
            default: lamp_at = 1'b0;
        endcase
    endfunction

    function automatic logic calls_above(input logic [1:0] idx, input logic [2:0] calls);
        case (idx)
            2'd0:    calls_above = calls[1] | calls[2];
            2'd1:    calls_above = calls[2];
            default: calls_above = 1'b0;
        endcase
    endfunction

    function automatic logic calls_below(input logic [1:0] idx, input logic [2:0] calls);
        case (idx)
            2'd1:    calls_below = calls[0];
            2'd2:    calls_below = calls[0] | calls[1];
            default: calls_below = 1'b0;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      floor_q;
    logic            move_q, move_d;
    logic            dir_q, dir_d;
    logic            door_q, door_d;
    logic            arrived_q, arrived_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [2:0]      calls_s;
    logic            here_s;
    logic            ahead_s;
    logic            behind_s;
    logic            at_end_s;
    logic [1:0]      step_idx_s;
    logic            step_lamp_s;
    logic            step_ahead_s;

    // Next-state and next-output logic for the car controller.
    always_comb begin
        calls_s      = {led3, led2, led1};
        here_s       = lamp_at(idx_q, calls_s);
        ahead_s      = dir_q ? calls_above(idx_q, calls_s) : calls_below(idx_q, calls_s);
        behind_s     = dir_q ? calls_below(idx_q, calls_s) : calls_above(idx_q, calls_s);
        at_end_s     = dir_q ? (idx_q == IDX_TOP) : (idx_q == IDX_BOT);
        step_idx_s   = dir_q ? (idx_q + 2'd1) : (idx_q - 2'd1);
        step_lamp_s  = lamp_at(step_idx_s, calls_s);
        step_ahead_s = dir_q ? calls_above(step_idx_s, calls_s) : calls_below(step_idx_s, calls_s);

        state_d   = state_q;
        idx_d     = idx_q;
        move_d    = move_q;
        dir_d     = dir_q;
        door_d    = door_q;
        arrived_d = 1'b0;
        timer_d   = timer_q;

        case (state_q)
            S_IDLE: begin
                if (here_s) begin
                    state_d   = S_DOOR;
                    door_d    = 1'b1;
                    arrived_d = 1'b1;
                    move_d    = 1'b0;
                    timer_d   = TIMER_ZERO;
                end else if (ahead_s) begin
                    state_d = S_MOVING;
                    move_d  = 1'b1;
                    door_d  = 1'b0;
                    timer_d = TIMER_ZERO;
                end else if (behind_s) begin
                    state_d = S_MOVING;
                    move_d  = 1'b1;
                    door_d  = 1'b0;
                    dir_d   = ~dir_q;
                    timer_d = TIMER_ZERO;
                end else begin
                    state_d = S_IDLE;
                end
            end

            // Calls are only looked at on the cycle the car reaches the next floor.
            S_MOVING: begin
                if (timer_q == TRAVEL_LAST) begin
                    timer_d = TIMER_ZERO;
                    if (at_end_s) begin
                        state_d = S_IDLE;
                        move_d  = 1'b0;
                    end else begin
                        idx_d = step_idx_s;
                        if (step_lamp_s) begin
                            state_d   = S_DOOR;
                            move_d    = 1'b0;
                            door_d    = 1'b1;
                            arrived_d = 1'b1;
                        end else if (step_ahead_s) begin
                            state_d = S_MOVING;
                        end else begin
                            state_d = S_IDLE;
                            move_d  = 1'b0;
                        end
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            // The arrival cycle still sees the call that opened the door, so it
            // cannot restart the timer; later presses of the same floor can.
            S_DOOR: begin
                if (here_s && !arrived_q) begin
                    timer_d = TIMER_ZERO;
                end else if (timer_q == DOOR_LAST) begin
                    state_d = S_IDLE;
                    door_d  = 1'b0;
                    timer_d = TIMER_ZERO;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                move_d  = 1'b0;
                door_d  = 1'b0;
                timer_d = TIMER_ZERO;
            end
        endcase
    end

    // State, timer and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= IDX_BOT;
            floor_q   <= labelF1;
            move_q    <= 1'b0;
            dir_q     <= 1'b1;
            door_q    <= 1'b0;
            arrived_q <= 1'b0;
            timer_q   <= TIMER_ZERO;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            floor_q   <= floor_code(idx_d);
            move_q    <= move_d;
            dir_q     <= dir_d;
            door_q    <= door_d;
            arrived_q <= arrived_d;
            timer_q   <= timer_d;
        end
    end

    assign floor        = floor_q;
    assign move_handler = move_q;
    assign dir_up       = dir_q;
    assign door_open    = door_q;
    assign arrived      = arrived_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller: each stimulus step queues the
// output changes it should cause (cycle and value); a monitor checks them.
module tb_elevator_controller;

    logic       clk;
    logic       reset;
    logic       led1, led2, led3;
    logic [1:0] floor;
    logic       move_handler, dir_up, door_open, arrived;

    elevator_controller #(
        .labelF1(2'b00), .labelF2(2'b01), .labelF3(2'b10),
        .TRAVEL_CYCLES(8), .DOOR_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset),
        .led1(led1), .led2(led2), .led3(led3),
        .floor(floor), .move_handler(move_handler), .dir_up(dir_up),
        .door_open(door_open), .arrived(arrived)
    );

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] prev_snap = 6'bxxxxxx;
    logic [5:0] snap;
    exp_t       e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Expected snapshot {floor, move_handler, dir_up, door_open, arrived}.
    task automatic push(input int c, input logic [1:0] f, input logic m,
                        input logic d, input logic o, input logic a);
        exp_t x;
        x.cyc = c;
        x.val = {f, m, d, o, a};
        exp_q.push_back(x);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every change of the output vector must match the next queued entry.
    always @(negedge clk) begin
        snap = {floor, move_handler, dir_up, door_open, arrived};
        if (snap !== prev_snap) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, snap);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val !== snap) begin
                    errors = errors + 1;
                    $display("FAIL out_change got cyc=%0d val=%b required cyc=%0d val=%b",
                             cyc, snap, e.cyc, e.val);
                end
            end
            prev_snap = snap;
        end
    end

    initial begin
        reset = 1'b1; led1 = 1'b0; led2 = 1'b0; led3 = 1'b0;
        push(1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Call to floor 3 from reset: two floor steps, door, idle.
        goto(2);   reset = 1'b0; led3 = 1'b1;
        push(3,  2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        push(11, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        push(19, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        goto(19);  led3 = 1'b0;
        push(20, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        push(23, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset beats a simultaneous call, then the call is served in place.
        goto(25);  reset = 1'b1; led1 = 1'b1;
        push(26, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        goto(26);  reset = 1'b0;
        push(27, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        goto(27);  led1 = 1'b0;
        push(28, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        push(31, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Intermediate call raised mid-travel stops the car at floor 2.
        goto(33);  led3 = 1'b1;
        push(34, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        goto(37);  led2 = 1'b1;
        push(42, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        goto(42);  led2 = 1'b0;
        push(43, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        push(46, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        push(47, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        push(55, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        goto(55);  led3 = 1'b0;
        push(56, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        push(59, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);

        // Park at floor 2 heading up, then calls on both sides.
        goto(61);  reset = 1'b1;
        push(62, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        goto(62);  reset = 1'b0; led2 = 1'b1;
        push(63, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        push(71, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        goto(71);  led2 = 1'b0;
        push(72, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        push(75, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        goto(75);  led1 = 1'b1; led3 = 1'b1;
        push(76, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        push(84, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        goto(84);  led3 = 1'b0;
        push(85,  2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        push(88,  2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        push(89,  2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        push(97,  2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        push(105, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        goto(105); led1 = 1'b0;
        push(106, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        push(109, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Behind-only call reverses direction; re-press at floor 2 extends the door.
        goto(111); led2 = 1'b1;
        push(112, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        push(120, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        goto(120); led2 = 1'b0;
        push(121, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        goto(121); led2 = 1'b1;
        goto(122); led2 = 1'b0;
        push(126, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-travel and reset with the door open.
        goto(127); reset = 1'b1;
        push(128, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        goto(128); reset = 1'b0; led3 = 1'b1;
        push(129, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        goto(133); reset = 1'b1;
        push(134, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        goto(134); reset = 1'b0; led3 = 1'b0;
        goto(136); led1 = 1'b1;
        push(137, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        goto(137); led1 = 1'b0; reset = 1'b1;
        push(138, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        goto(138); reset = 1'b0;

        goto(145);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL pending_expectations got=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
